// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC sequencer: default sizes, ALU op codes
// and the sequencer state encoding.
package fir_pkg;

    localparam int FIR_NTAPS   = 64;
    localparam int FIR_DW      = 16;
    localparam int FIR_RW      = 32;
    localparam int FIR_ALU_LAT = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Bundle of the sample handshake, coefficient write port, ALU operand/result
// bus, filter output and status signals of the FIR MAC sequencer.
//
// Sample handshake: a sample transfers on the rising edge where in_valid and
// in_ready are both high. The source keeps in_valid and in_sample stable until
// that edge; in_valid while in_ready is low has no effect. The output side has
// no ready: out_valid is a one-cycle pulse and out_data holds until the next.
interface fir_mac_sequencer_if
    import fir_pkg::*;
#(
    parameter int NTAPS = FIR_NTAPS,
    parameter int DW    = FIR_DW,
    parameter int RW    = FIR_RW
);
    localparam int AW = $clog2(NTAPS);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_sample;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [DW-1:0] coef_wdata;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_op_sel;
    logic [RW-1:0] alu_result;
    logic          out_valid;
    logic [RW-1:0] out_data;
    logic          busy;
    state_t        dbg_state;

    // Sequencer side.
    modport slave (
        input  in_valid, in_sample, coef_we, coef_addr, coef_wdata, alu_result,
        output in_ready, alu_a, alu_b, alu_op_sel, out_valid, out_data, busy,
        dbg_state
    );

    // Environment side: sample source, coefficient loader, ALU, consumer.
    modport master (
        output in_valid, in_sample, coef_we, coef_addr, coef_wdata, alu_result,
        input  in_ready, alu_a, alu_b, alu_op_sel, out_valid, out_data, busy,
        dbg_state
    );

endinterface

// File: rtl/fir_hist_buf.sv
// Circular sample history. Each accepted sample is written at the write
// pointer, which then advances and wraps at NTAPS. The read port is
// combinational so the sequencer can present a tap in the same cycle it
// computes the index.
module fir_hist_buf
    import fir_pkg::*;
#(
    parameter  int NTAPS = FIR_NTAPS,
    parameter  int DW    = FIR_DW,
    localparam int AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_rd_idx,
    output logic [AW-1:0] o_wr_ptr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [NTAPS];
    logic [AW-1:0] r_wr_ptr;

    // Write the new sample and advance the pointer; reset clears the history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
        end
    end

    assign o_wr_ptr  = r_wr_ptr;
    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR MAC sequencer: per accepted sample, issues one multiply per tap to the
// shared pipelined ALU, tags each op in a valid shift register whose tail
// lines up with the returning result, accumulates modulo 2^RW and emits one
// output pulse once the final tagged product has been summed.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS   = FIR_NTAPS,
    parameter int DW      = FIR_DW,
    parameter int RW      = FIR_RW,
    parameter int ALU_LAT = FIR_ALU_LAT
) (
    input  logic                clk,
    input  logic                rst,
    fir_mac_sequencer_if.slave  bus
);

    localparam int AW = $clog2(NTAPS);
    localparam logic [AW-1:0]      TAP_LAST  = AW'(NTAPS - 1);
    // Only the oldest tag left in flight: its result arrives this cycle.
    localparam logic [ALU_LAT-1:0] TAIL_MASK = ALU_LAT'(1) << (ALU_LAT - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_base;
    logic [AW-1:0]      r_tap;
    logic [DW-1:0]      r_coef [NTAPS];
    logic [ALU_LAT-1:0] r_vsr;
    logic [RW-1:0]      r_acc;
    logic [RW-1:0]      r_out_data;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_push;
    logic               w_vsr_tail;
    logic               w_last_result;
    logic [RW-1:0]      w_acc_sum;
    logic [AW-1:0]      w_wr_ptr;
    logic [AW-1:0]      w_rd_idx;
    logic [DW-1:0]      w_hist_rd;
    logic [DW-1:0]      w_alu_a;
    logic [DW-1:0]      w_alu_b;
    logic [1:0]         w_alu_op;

    assign w_accept      = (r_state == IDLE) && bus.in_valid;
    assign w_vsr_tail    = r_vsr[ALU_LAT-1];
    assign w_last_result = (r_state == DRAIN) && (r_vsr == TAIL_MASK);
    assign w_acc_sum     = r_acc + bus.alu_result;
    // Tap k pairs coefficient k with the sample k steps older than the newest.
    assign w_rd_idx      = r_base - r_tap;

    fir_hist_buf #(
        .NTAPS (NTAPS),
        .DW    (DW)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_accept),
        .i_wdata   (bus.in_sample),
        .i_rd_idx  (w_rd_idx),
        .o_wr_ptr  (w_wr_ptr),
        .o_rd_data (w_hist_rd)
    );

    // Next-state and ALU operand selection; operands are zero outside ISSUE.
    always_comb begin
        w_state_next = r_state;
        w_alu_a      = '0;
        w_alu_b      = '0;
        w_alu_op     = OP_ADD;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_alu_a  = w_hist_rd;
                w_alu_b  = r_coef[r_tap];
                w_alu_op = OP_MUL;
                w_push   = 1'b1;
                if (r_tap == TAP_LAST) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_vsr == '0) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register, tap counter and the history slot of the current sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_tap   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_base <= w_wr_ptr;
                r_tap  <= '0;
            end else if (r_state == ISSUE) begin
                r_tap  <= r_tap + AW'(1);
            end
        end
    end

    // Coefficient bank: writes land only while IDLE, so a running sample never
    // sees its coefficients change underneath it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if ((r_state == IDLE) && bus.coef_we) begin
            r_coef[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    // Valid shift register and accumulator; a tail bit marks a result to add.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsr <= '0;
            r_acc <= '0;
        end else begin
            r_vsr <= (r_vsr << 1) | ALU_LAT'(w_push);
            if (w_accept) begin
                r_acc <= '0;
            end else if (w_vsr_tail) begin
                r_acc <= w_acc_sum;
            end
        end
    end

    // Capture the final sum with its last product folded in and pulse once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_last_result;
            if (w_last_result) begin
                r_out_data <= w_acc_sum;
            end
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.alu_a      = w_alu_a;
    assign bus.alu_b      = w_alu_b;
    assign bus.alu_op_sel = w_alu_op;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a behavioural pipelined ALU.
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    localparam int NTAPS   = 64;
    localparam int DW      = 16;
    localparam int RW      = 32;
    localparam int ALU_LAT = 3;
    localparam int AW      = $clog2(NTAPS);
    localparam int OUT_LAT = NTAPS + ALU_LAT + 1;  // 68 cycles accept->out_valid

    logic clk;
    logic rst;

    fir_mac_sequencer_if #(.NTAPS(NTAPS), .DW(DW), .RW(RW)) bus ();

    fir_mac_sequencer #(
        .NTAPS   (NTAPS),
        .DW      (DW),
        .RW      (RW),
        .ALU_LAT (ALU_LAT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] alu_pipe [ALU_LAT];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural ALU ----------------
    function automatic logic [RW-1:0] alu_f(input logic [1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic signed [RW-1:0] sa;
        logic signed [RW-1:0] sb;
        sa = RW'($signed(a));
        sb = RW'($signed(b));
        if (op == OP_MUL) return sa * sb;
        return RW'(a) + RW'(b);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ALU_LAT; i++) alu_pipe[i] <= '0;
        end else begin
            alu_pipe[0] <= alu_f(bus.alu_op_sel, bus.alu_a, bus.alu_b);
            for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
        end
    end
    assign bus.alu_result = alu_pipe[ALU_LAT-1];

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
        check_eq({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        check_eq({tag, "_out_data"},   32'(bus.out_data),   32'd0);
        check_eq({tag, "_busy"},       32'(bus.busy),       32'd0);
        check_eq({tag, "_alu_a"},      32'(bus.alu_a),      32'd0);
        check_eq({tag, "_alu_b"},      32'(bus.alu_b),      32'd0);
        check_eq({tag, "_alu_op_sel"}, 32'(bus.alu_op_sel), 32'(OP_ADD));
        check_eq({tag, "_state"},      32'(bus.dbg_state),  32'(IDLE));
    endtask

    task automatic score_output(input string tag);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_unexpected_out"}, 32'd1, 32'd0);
        end else begin
            check_eq({tag, "_out_data"}, 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input logic [DW-1:0] data);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = AW'(addr);
        bus.coef_wdata = data;
        @(negedge clk);
        bus.coef_we    = 1'b0;
    endtask

    // Send one sample, optionally writing a coefficient on the accept edge
    // (acc_we) or on cycle mid_cyc after it (0 = none), then check the
    // output value and the full cycle profile up to in_ready returning.
    task automatic run_one(input string tag, input logic [DW-1:0] smp,
                           input logic [RW-1:0] exp, input logic acc_we,
                           input int mid_cyc, input int waddr,
                           input logic [DW-1:0] wdata);
        int n;
        int out_at;
        int out_cnt;
        int bad_rdy;
        int bad_op;
        int bad_busy;
        int bad_ab;
        logic exp_rdy;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready_before"}, 32'(bus.in_ready), 32'd1);
        exp_q.push_back(exp);
        bus.in_valid  = 1'b1;
        bus.in_sample = smp;
        if (acc_we) begin
            bus.coef_we    = 1'b1;
            bus.coef_addr  = AW'(waddr);
            bus.coef_wdata = wdata;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.coef_we   = 1'b0;
        out_at = 0; out_cnt = 0; bad_rdy = 0; bad_op = 0; bad_busy = 0; bad_ab = 0;
        for (int j = 1; j <= OUT_LAT + 1; j++) begin
            exp_rdy = (j == OUT_LAT + 1);
            if (bus.in_ready !== exp_rdy) bad_rdy++;
            if (bus.busy !== !exp_rdy) bad_busy++;
            if (bus.alu_op_sel !== ((j <= NTAPS) ? OP_MUL : OP_ADD)) bad_op++;
            if (j > NTAPS && (bus.alu_a !== '0 || bus.alu_b !== '0)) bad_ab++;
            if (bus.out_valid) begin
                out_cnt++;
                out_at = j;
                score_output(tag);
            end
            if (j <= OUT_LAT) begin
                bus.coef_we    = (j == mid_cyc);
                bus.coef_addr  = AW'(waddr);
                bus.coef_wdata = wdata;
                @(negedge clk);
            end
        end
        bus.coef_we = 1'b0;
        check_eq({tag, "_pulse_count"},   32'(out_cnt),  32'd1);
        check_eq({tag, "_out_latency"},   32'(out_at),   32'(OUT_LAT));
        check_eq({tag, "_ready_profile"}, 32'(bad_rdy),  32'd0);
        check_eq({tag, "_busy_profile"},  32'(bad_busy), 32'd0);
        check_eq({tag, "_op_profile"},    32'(bad_op),   32'd0);
        check_eq({tag, "_drain_zero_ab"}, 32'(bad_ab),   32'd0);
        if (exp_q.size() != 0) begin
            check_eq({tag, "_missing_out"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        int idx;
        int outs;
        int acc_cyc [3];
        logic accept_now;
        logic [DW-1:0] bp_smp [3];

        rst = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sample  = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("por");

        // Impulse response: coef[k] = k+1, feed 1 then 63 zeros.
        for (int k = 0; k < NTAPS; k++) write_coef(k, DW'(k + 1));
        for (int n = 0; n < NTAPS; n++) begin
            run_one("impulse", (n == 0) ? DW'(1) : DW'(0), RW'(n + 1), 1'b0, 0, 0, '0);
        end

        // Wrap-around: 0x7FFF * 0x7FFF = 0x3FFF0001 per tap, n taps filled.
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'h7FFF);
        for (int n = 1; n < NTAPS; n++) begin
            run_one("wrap", 16'h7FFF, 32'(64'(n) * 64'h3FFF0001), 1'b0, 0, 0, '0);
        end
        run_one("wrap_full", 16'h7FFF, 32'hFFC00040, 1'b0, 0, 0, '0);

        // Coefficient write during ISSUE is dropped.
        pulse_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'd1);
        run_one("ign_wr_a", 16'd2, 32'd2, 1'b0, 10, 0, 16'd5);
        run_one("ign_wr_b", 16'd3, 32'd5, 1'b0, 0, 0, '0);
        run_one("coef0_readback", 16'd4, 32'd9, 1'b0, 0, 0, '0);
        // Write on the accept edge applies to that sample: 1*3 + 4 + 3 + 2.
        run_one("same_edge_wr", 16'd1, 32'd12, 1'b1, 0, 0, 16'd3);

        // Reset at tap 30 of an in-flight sample.
        bus.in_valid  = 1'b1;
        bus.in_sample = 16'd9;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        repeat (30) @(negedge clk);
        check_eq("mid_tap30_op", 32'(bus.alu_op_sel), 32'(OP_MUL));
        pulse_reset();
        check_reset_outputs("mid_rst");
        pulses = 0;
        for (int c = 0; c < OUT_LAT + 10; c++) begin
            if (bus.out_valid) pulses++;
            @(negedge clk);
        end
        check_eq("mid_rst_no_pulse", 32'(pulses), 32'd0);
        write_coef(0, 16'd1);
        run_one("after_rst", 16'd7, 32'd7, 1'b0, 0, 0, '0);

        // Backpressure: in_valid held high; history is 7 then 1,2,3, all coef 1.
        for (int k = 1; k < NTAPS; k++) write_coef(k, 16'd1);
        bp_smp[0] = 16'd1; bp_smp[1] = 16'd2; bp_smp[2] = 16'd3;
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd13);
        idx  = 0;
        outs = 0;
        for (int i = 0; i < 3; i++) acc_cyc[i] = 0;
        bus.in_valid  = 1'b1;
        bus.in_sample = bp_smp[0];
        for (int cyc = 0; cyc < 3 * (OUT_LAT + 1) + 10; cyc++) begin
            if (bus.out_valid) begin
                outs++;
                score_output("bp");
            end
            accept_now = bus.in_valid && bus.in_ready;
            if (accept_now) begin
                if (idx < 3) acc_cyc[idx] = cyc;
                idx++;
            end
            @(negedge clk);
            if (accept_now) begin
                if (idx < 3) bus.in_sample = bp_smp[idx];
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check_eq("bp_accepts", 32'(idx), 32'd3);
        check_eq("bp_outputs", 32'(outs), 32'd3);
        check_eq("bp_gap_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(OUT_LAT + 1));
        check_eq("bp_gap_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(OUT_LAT + 1));
        check_eq("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Sequencing controller for the FIR core's shared ALU. It accepts one input sample at a time and keeps an NTAPS-deep sample history plus an NTAPS-entry coefficient bank. For each sample it issues one ALU multiply per tap, accumulates the returning products modulo 2^32, and emits one filter output. It sits between the sample source and the `alu` instance, and is the only block that drives `a`, `b` and `op_sel` on that ALU.

## Interface
Parameters:
- NTAPS, 64 — number of filter taps; power of two, ≥2.
- DW, 16 — sample and coefficient width; matches the ALU `a`/`b` width.
- RW, 32 — ALU result and accumulator width.
- ALU_LAT, 3 — cycles from an op presented on `alu_*` to its `alu_result`; the ALU is fully pipelined and accepts one op per cycle.

Ports:
- clk  in  1  — single clock, rising edge.
- rst  in  1  — reset, synchronous, active-high.
- in_valid  in  1  — sample offered.
- in_ready  out  1  — sequencer can accept a sample.
- in_sample  in  DW  — sample data.
- coef_we  in  1  — coefficient write strobe.
- coef_addr  in  log2(NTAPS)  — tap index to write.
- coef_wdata  in  DW  — coefficient value.
- alu_a  out  DW  — ALU operand a (sample).
- alu_b  out  DW  — ALU operand b (coefficient).
- alu_op_sel  out  2  — ALU op select: 00 = add, 01 = multiply.
- alu_result  in  RW  — ALU result.
- out_valid  out  1  — one-cycle pulse; out_data is valid.
- out_data  out  RW  — filter output, held until the next pulse.
- busy  out  1  — a computation is in progress (state is not IDLE).

## Operation
States and transitions:
- IDLE: in_ready=1.
  - On in_valid, write in_sample into the history at wr_ptr, latch base=wr_ptr, increment wr_ptr (wraps at NTAPS), clear the accumulator, go to ISSUE.
- ISSUE: one multiply per cycle for tap k = 0..NTAPS-1.
  - alu_a = hist[(base-k) mod NTAPS], alu_b = coef[k], alu_op_sel = 01.
  - Push a 1 into an ALU_LAT-deep valid shift register.
  - After k = NTAPS-1, go to DRAIN.
- DRAIN: alu_op_sel = 00, alu_a = alu_b = 0, push 0s into the valid shift register.
  - When the last tagged result has been accumulated, load out_data and pulse out_valid; go to IDLE.
- Every cycle in which the valid shift-register tail is 1, add alu_result into the accumulator.
- Outside ISSUE, alu_op_sel = 00 and alu_a = alu_b = 0.

Arithmetic:
- acc <= acc + alu_result, truncated to RW bits (wrap, no saturation). This is signedness-agnostic.

Coefficients:
- A coefficient is written only when coef_we is asserted in IDLE. A write in any other state is dropped.
- When coef_we and an accepted in_valid occur on the same edge, both take effect. The new coefficient is used for this sample.

Reset (also applies mid-operation):
- State returns to IDLE; wr_ptr = 0; accumulator = 0; valid shift register = 0; all history and coefficient entries = 0.
- Output reset values: in_ready=1, out_valid=0, out_data=0, busy=0, alu_a=0, alu_b=0, alu_op_sel=00.
- In-flight ALU results are discarded. No out_valid pulse is produced for an interrupted sample.

## Timing
- Accept edge T: the edge on which in_valid && in_ready.
- in_ready falls in cycle T+1. Taps 0..NTAPS-1 are driven in cycles T+1..T+NTAPS.
- out_valid is high in cycle T+NTAPS+ALU_LAT+1, for exactly one cycle. Default parameters give 68 cycles.
- in_ready returns high in the cycle after the out_valid pulse. The earliest next accept edge is T+NTAPS+ALU_LAT+2.
- There is no output backpressure; the consumer must capture on the out_valid pulse.
- in_valid while in_ready=0 is ignored. The source holds the sample until accepted.

## Structure
- Shared package `fir_pkg`:
  - DW, RW, NTAPS defaults.
  - OP_ADD = 2'b00, OP_MUL = 2'b01.
  - State enum {IDLE, ISSUE, DRAIN}.
- Sub-module `fir_hist_buf`:
  - Circular NTAPS×DW sample buffer with wr_ptr, synchronous clear on rst, and a combinational read port indexed by (base-k).
- The coefficient bank, FSM, tap counter, valid shift register and accumulator stay in `fir_mac_sequencer`.

## Test plan
Bench: behavioural ALU model with ALU_LAT=3, NTAPS=64.
- Impulse response: coef[k]=k+1; feed 1 then 63 zeros → outputs 1, 2, …, 64.
- Latency: single accept at edge T → out_valid high only in cycle T+68; in_ready low for cycles T+1..T+68 and high again in T+69; ALU op sequence shows 64 cycles of op_sel=01 followed by op_sel=00.
- Wrap-around: all coef = 0x7FFF; feed 64 samples of 0x7FFF → 64th output = 0xFFC00040 (4290773056).
- Ignored coefficient write: with all coef=1, write coef[0]=5 during ISSUE; feed samples 2, 3 → outputs 2, 5; a coef[0] read-back after returning to IDLE shows 1.
- Reset mid-operation: assert rst for one cycle at tap 30 → no out_valid pulse; all outputs at reset values; next sample 7 with coef[0]=1, other coefs 0 → output 7 (history was cleared).
- Backpressure: hold in_valid high continuously with samples 1, 2, 3 → exactly one accept per 69 cycles, no sample lost or duplicated.
